pc_flag_unit: RTL
=================

Name: pc_flag_unit

Overview:
- Program-counter and condition-code block for the single-cycle processor; consumes the ALU's N/V/Z flag outputs.
- Holds the architectural flag register and evaluates the 3-bit branch condition against it.
- Computes and registers the next PC for sequential flow, PC-relative branches (B) and register branches (BR).
- Implements the sticky HLT state.

Parameters:
- PC_W, 16, width of PC, addresses and register target
- IMM_W, 9, width of the signed branch offset field
- RESET_PC, 16'h0000, PC value loaded on reset

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- en  input  1  global advance enable; 0 = stall, all state held
- flag_in  input  3  ALU flags, [0]=N [1]=V [2]=Z
- flag_we  input  3  per-bit flag write enable, same bit order
- is_b  input  1  current instruction is B (PC-relative conditional)
- is_br  input  1  current instruction is BR (register conditional)
- cond  input  3  condition code field
- imm  input  IMM_W  signed word offset for B
- reg_target  input  PC_W  target address for BR
- halt_in  input  1  current instruction is HLT
- pc  output  PC_W  current PC (instruction fetch address)
- pc_plus2  output  PC_W  pc + 2, combinational
- flags  output  3  registered flags, [0]=N [1]=V [2]=Z
- taken  output  1  combinational: branch/BR condition true this cycle
- halted  output  1  sticky halt indicator

Behaviour:
- Reset (asynchronous, any time, including mid-stall or while halted):
  - pc=RESET_PC, flags=3'b000, halted=0.
  - pc_plus2 and taken follow combinationally.
- Condition evaluation uses the registered flags (N, V, Z), never flag_in:
  - 000 NE: Z=0
  - 001 EQ: Z=1
  - 010 GT: Z=0 & N=0
  - 011 LT: N=1
  - 100 GTE: Z=1 | (Z=0 & N=0)
  - 101 LTE: N=1 | Z=1
  - 110 OV: V=1
  - 111 UN: always true
- taken = (is_b | is_br) & cond_true & ~halted.
- Branch target: b_target = pc_plus2 + (sign_extend(imm) << 1).
- All address arithmetic is modulo 2^PC_W; wrap from 16'hFFFE to 16'h0000 is silent and legal.
- next_pc priority, highest first:
  1. halted or halt_in: pc.
  2. is_br & taken: reg_target.
  3. is_b & taken: b_target.
  4. Otherwise: pc_plus2.
- is_b and is_br both high: BR wins.
- Rising edge with en=1 and halted=0:
  - pc <= next_pc.
  - Each flags[i] <= flag_in[i] where flag_we[i]=1; bits with flag_we[i]=0 hold.
  - halted <= halt_in.
- Halt cycle (halt_in=1): flag writes suppressed; pc holds at the HLT address.
- Rising edge with en=0: pc, flags and halted all hold. Inputs are ignored except for the combinational outputs.
- halted=1: no state changes until rst; taken forced 0; pc frozen at the HLT address.
- Latency:
  - Branch decision and flag write take effect on the same edge, one cycle.
  - A flag written by instruction k is visible to the branch at instruction k+1.
  - No bypass from flag_in to the condition evaluator.
- Outputs change only on clock edges or rst, except pc_plus2 and taken, which are combinational.

Test Plan:
- Reset and sequential flow:
  - Stimulus: assert rst mid-run, release, en=1, no branches for 4 cycles.
  - Required: pc 0000→0002→0004→0006→0008; flags=000; halted=0.
- Flag mask plus EQ/NE:
  - Stimulus: flag_in=3'b111, flag_we=3'b100; next cycle is_b=1, cond=001, imm=9'h004, pc=0010.
  - Required: flags=100; taken=1; pc becomes 001A. Repeat with cond=000: taken=0, pc 0012.
- Negative offset and wrap:
  - Stimulus: pc=0002, is_b=1, cond=111, imm=9'h1FD (-3).
  - Required: pc=FFFE. A following sequential cycle gives pc=0000.
- BR priority and OV:
  - Stimulus: flags V=1, is_b=1, is_br=1, cond=110, reg_target=1234, imm=9'h010.
  - Required: taken=1; pc=1234.
- Stall:
  - Stimulus: en=0 for 3 cycles with is_b=1, cond=111, flag_we=111.
  - Required: pc and flags unchanged; taken=1 combinationally. Raise en: pc takes b_target on the next edge.
- Halt and reset recovery:
  - Stimulus: halt_in=1 at pc=0020 with flag_we=111.
  - Required: halted=1; pc stays 0020; flags unchanged; further branches ignored. Assert rst asynchronously: pc=0000 and halted=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pc_flag_unit.sv
// Program counter, condition-code register and sticky halt for the
// single-cycle core: evaluates branch conditions and registers the next PC.
module pc_flag_unit #(
   parameter int              PC_W     = 16,
   parameter int              IMM_W    = 9,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [2:0]       flag_in,
   input  logic [2:0]       flag_we,
   input  logic             is_b,
   input  logic             is_br,
   input  logic [2:0]       cond,
   input  logic [IMM_W-1:0] imm,
   input  logic [PC_W-1:0]  reg_target,
   input  logic             halt_in,
   output logic [PC_W-1:0]  pc,
   output logic [PC_W-1:0]  pc_plus2,
   output logic [2:0]       flags,
   output logic             taken,
   output logic             halted
);

   logic [PC_W-1:0] pc_q, pc_d;
   logic [2:0]      flags_q, flags_d;
   logic            halted_q, halted_d;

   logic            n_f, v_f, z_f;
   logic            cond_true;
   logic [PC_W-1:0] imm_ext;
   logic [PC_W-1:0] b_target;
   logic [PC_W-1:0] next_pc;

   assign n_f = flags_q[0];
   assign v_f = flags_q[1];
   assign z_f = flags_q[2];

   // Conditions see only registered flags; no bypass from flag_in.
   always_comb begin
      cond_true = 1'b0;
      case (cond)
         3'b000:  cond_true = ~z_f;
         3'b001:  cond_true = z_f;
         3'b010:  cond_true = ~z_f & ~n_f;
         3'b011:  cond_true = n_f;
         3'b100:  cond_true = z_f | (~z_f & ~n_f);
         3'b101:  cond_true = n_f | z_f;
         3'b110:  cond_true = v_f;
         default: cond_true = 1'b1;
      endcase
   end

   assign pc_plus2 = pc_q + PC_W'(2);
   assign imm_ext  = {{(PC_W-IMM_W){imm[IMM_W-1]}}, imm};
   assign b_target = pc_plus2 + (imm_ext << 1);
   assign taken    = (is_b | is_br) & cond_true & ~halted_q;

   always_comb begin
      next_pc = pc_plus2;
      if (halted_q | halt_in)
         next_pc = pc_q;
      else if (is_br & taken)
         next_pc = reg_target;
      else if (is_b & taken)
         next_pc = b_target;
   end

   always_comb begin
      pc_d     = pc_q;
      flags_d  = flags_q;
      halted_d = halted_q;
      if (en && !halted_q) begin
         pc_d     = next_pc;
         halted_d = halt_in;
         if (!halt_in)
            flags_d = (flags_q & ~flag_we) | (flag_in & flag_we);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q     <= RESET_PC;
         flags_q  <= 3'b000;
         halted_q <= 1'b0;
      end else begin
         pc_q     <= pc_d;
         flags_q  <= flags_d;
         halted_q <= halted_d;
      end
   end

   assign pc     = pc_q;
   assign flags  = flags_q;
   assign halted = halted_q;

endmodule
